seg_hazard_unit: RTL and testbench

Pipeline controller for the five-stage MIPS core: computes and registers the forwarding selects consumed by the execute stage, detects load-use hazards and inserts bubbles, flushes wrong-path instructions on taken branches and jumps, and sequences run, single-step and halt-drain modes for the debug interface. Sits beside the ID/EX boundary and drives every pipeline-register enable and flush in the core.

---
 rtl/seg_pipe_pkg.sv | 33 +++
 rtl/seg_forwarding_unit.sv | 30 +++
 rtl/seg_hazard_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_seg_hazard_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pipe_pkg.sv
// Shared types for the pipeline hazard/debug controller.
//   fwd_sel_e    : execute-stage operand source codes
//   pipe_state_e : run / single-step / halt-drain sequencer states
//   hazard_ctl_t : bundle of pipeline-register enables, flushes and PC select
package seg_pipe_pkg;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STEP_WAIT = 3'd1,
        ST_STEP_EXEC = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic pc_src;
    } hazard_ctl_t;

endpackage

// File: rtl/seg_forwarding_unit.sv
// Forwarding select for one ID source operand.
//   i_src                      : source register read in ID
//   i_ex_write_reg/_reg_write  : producer one stage ahead (result lands in MEM)
//   i_mem_write_reg/_reg_write : producer two stages ahead (result lands in WB)
//   o_fwd_c                    : combinational select, youngest producer wins
module seg_forwarding_unit
    import seg_pipe_pkg::*;
#(
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_FWD  = 2
) (
    input  logic [NB_ADDR-1:0] i_src,
    input  logic [NB_ADDR-1:0] i_ex_write_reg,
    input  logic               i_ex_reg_write,
    input  logic [NB_ADDR-1:0] i_mem_write_reg,
    input  logic               i_mem_reg_write,
    output logic [NB_FWD-1:0]  o_fwd_c
);

    // $0 is hardwired zero and is never forwarded
    always_comb begin
        o_fwd_c = NB_FWD'(FWD_REG);
        if ((|i_src) && i_ex_reg_write && (i_src == i_ex_write_reg)) begin
            o_fwd_c = NB_FWD'(FWD_MEM);
        end else if ((|i_src) && i_mem_reg_write && (i_src == i_mem_write_reg)) begin
            o_fwd_c = NB_FWD'(FWD_WB);
        end
    end

endmodule

// File: rtl/seg_hazard_unit.sv
// Pipeline controller for the five-stage core.
//   Inputs : ID operands, EX/MEM destinations and write/read flags, jump,
//            taken branch, halt decode, debug step mode and step request.
//   Outputs: registered EX forwarding selects, combinational PC/IF-ID/ID-EX
//            enables, bubble and flushes, global advance enable, halted flag,
//            count of advancing cycles.
module seg_hazard_unit
    import seg_pipe_pkg::*;
#(
    parameter int unsigned NB_ADDR      = 5,
    parameter int unsigned NB_FWD       = 2,
    parameter int unsigned NB_CNT       = 32,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    input  logic [NB_ADDR-1:0] i_ex_write_reg,
    input  logic               i_ex_reg_write,
    input  logic               i_ex_mem_read,
    input  logic [NB_ADDR-1:0] i_mem_write_reg,
    input  logic               i_mem_reg_write,
    input  logic               i_id_jump,
    input  logic               i_mem_branch_taken,
    input  logic               i_id_halt,
    input  logic               i_step_mode,
    input  logic               i_step,
    output logic [NB_FWD-1:0]  o_fwd_a,
    output logic [NB_FWD-1:0]  o_fwd_b,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_id_ex_bubble,
    output logic               o_flush_if_id,
    output logic               o_flush_id_ex,
    output logic               o_flush_ex_mem,
    output logic               o_pc_src,
    output logic               o_pipe_en,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_cycle_count
);

    localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pipe_state_e          state_q;
    pipe_state_e          state_d;
    logic                 pipe_en;
    logic                 halted;
    logic                 step_prev_q;
    logic                 step_go_q;
    logic                 step_rise;
    logic [NB_DRAIN-1:0]  drain_cnt_q;
    logic                 drain_last;
    logic [NB_CNT-1:0]    cycle_cnt_q;
    logic [NB_FWD-1:0]    fwd_a_c;
    logic [NB_FWD-1:0]    fwd_b_c;
    logic [NB_FWD-1:0]    fwd_a_q;
    logic [NB_FWD-1:0]    fwd_b_q;
    logic                 load_use;
    hazard_ctl_t          haz;

    assign step_rise  = i_step & ~step_prev_q;
    assign drain_last = (drain_cnt_q == NB_DRAIN'(DRAIN_CYCLES - 1));

    // Operand forwarding compare, one per ID source
    seg_forwarding_unit #(
        .NB_ADDR (NB_ADDR),
        .NB_FWD  (NB_FWD)
    ) u_fwd_a (
        .i_src           (i_id_rs),
        .i_ex_write_reg  (i_ex_write_reg),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_mem_write_reg (i_mem_write_reg),
        .i_mem_reg_write (i_mem_reg_write),
        .o_fwd_c         (fwd_a_c)
    );

    seg_forwarding_unit #(
        .NB_ADDR (NB_ADDR),
        .NB_FWD  (NB_FWD)
    ) u_fwd_b (
        .i_src           (i_id_rt),
        .i_ex_write_reg  (i_ex_write_reg),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_mem_write_reg (i_mem_write_reg),
        .i_mem_reg_write (i_mem_reg_write),
        .o_fwd_c         (fwd_b_c)
    );

    // Sequencer state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and advance enable
    always_comb begin
        state_d = state_q;
        pipe_en = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_RUN: begin
                pipe_en = 1'b1;
                if (i_id_halt) begin
                    state_d = ST_DRAIN;
                end else if (i_step_mode) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (!i_step_mode) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    state_d = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                pipe_en = 1'b1;
                state_d = i_id_halt ? ST_DRAIN : ST_STEP_WAIT;
            end
            ST_DRAIN: begin
                // In step mode the drain only advances on a granted step
                pipe_en = i_step_mode ? step_go_q : 1'b1;
                if (pipe_en && drain_last) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Outputs stay quiet while reset is held
        if (!i_rst) begin
            pipe_en = 1'b0;
            halted  = 1'b0;
        end
    end

    // Hazard resolution: branch > load-use stall > jump, all gated by advance
    always_comb begin
        haz      = '0;
        load_use = i_ex_mem_read && (|i_ex_write_reg) &&
                   ((i_ex_write_reg == i_id_rs) || (i_ex_write_reg == i_id_rt));
        if (pipe_en) begin
            if (state_q == ST_DRAIN) begin
                haz.flush_if_id = 1'b1;
            end else if (i_mem_branch_taken) begin
                haz.pc_write     = 1'b1;
                haz.if_id_write  = 1'b1;
                haz.flush_if_id  = 1'b1;
                haz.flush_id_ex  = 1'b1;
                haz.flush_ex_mem = 1'b1;
                haz.pc_src       = 1'b1;
            end else if (load_use) begin
                haz.id_ex_bubble = 1'b1;
            end else begin
                haz.pc_write    = 1'b1;
                haz.if_id_write = 1'b1;
                haz.flush_if_id = i_id_jump;
            end
        end
    end

    // Step request edge detect; step_go_q grants one drain cycle in step mode
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            step_prev_q <= 1'b0;
            step_go_q   <= 1'b0;
        end else begin
            step_prev_q <= i_step;
            step_go_q   <= step_rise;
        end
    end

    // Enabled cycles spent draining
    always_ff @(posedge i_clk) begin
        if (!i_rst || (state_q != ST_DRAIN)) begin
            drain_cnt_q <= '0;
        end else if (pipe_en) begin
            drain_cnt_q <= drain_cnt_q + NB_DRAIN'(1);
        end
    end

    // Advancing-cycle counter, wraps naturally
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cycle_cnt_q <= '0;
        end else if (pipe_en) begin
            cycle_cnt_q <= cycle_cnt_q + NB_CNT'(1);
        end
    end

    // Forward selects load with ID/EX; a bubble carries no operands
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fwd_a_q <= NB_FWD'(FWD_REG);
            fwd_b_q <= NB_FWD'(FWD_REG);
        end else if (pipe_en) begin
            fwd_a_q <= haz.id_ex_bubble ? NB_FWD'(FWD_REG) : fwd_a_c;
            fwd_b_q <= haz.id_ex_bubble ? NB_FWD'(FWD_REG) : fwd_b_c;
        end
    end

    assign o_fwd_a        = fwd_a_q;
    assign o_fwd_b        = fwd_b_q;
    assign o_pc_write     = haz.pc_write;
    assign o_if_id_write  = haz.if_id_write;
    assign o_id_ex_bubble = haz.id_ex_bubble;
    assign o_flush_if_id  = haz.flush_if_id;
    assign o_flush_id_ex  = haz.flush_id_ex;
    assign o_flush_ex_mem = haz.flush_ex_mem;
    assign o_pc_src       = haz.pc_src;
    assign o_pipe_en      = pipe_en;
    assign o_halted       = halted;
    assign o_cycle_count  = cycle_cnt_q;

endmodule

// File: tb/tb_seg_hazard_unit.sv
// Bench for seg_hazard_unit: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_seg_hazard_unit;

    localparam int unsigned NB_ADDR      = 5;
    localparam int unsigned NB_FWD       = 2;
    localparam int unsigned NB_CNT       = 32;
    localparam int unsigned DRAIN_CYCLES = 3;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [NB_ADDR-1:0] i_id_rs, i_id_rt, i_ex_write_reg, i_mem_write_reg;
    logic               i_ex_reg_write, i_ex_mem_read, i_mem_reg_write;
    logic               i_id_jump, i_mem_branch_taken, i_id_halt, i_step_mode, i_step;
    logic [NB_FWD-1:0]  o_fwd_a, o_fwd_b;
    logic               o_pc_write, o_if_id_write, o_id_ex_bubble;
    logic               o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_pc_src;
    logic               o_pipe_en, o_halted;
    logic [NB_CNT-1:0]  o_cycle_count;

    always #5 i_clk = ~i_clk;

    seg_hazard_unit #(
        .NB_ADDR      (NB_ADDR),
        .NB_FWD       (NB_FWD),
        .NB_CNT       (NB_CNT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_id_rs            (i_id_rs),
        .i_id_rt            (i_id_rt),
        .i_ex_write_reg     (i_ex_write_reg),
        .i_ex_reg_write     (i_ex_reg_write),
        .i_ex_mem_read      (i_ex_mem_read),
        .i_mem_write_reg    (i_mem_write_reg),
        .i_mem_reg_write    (i_mem_reg_write),
        .i_id_jump          (i_id_jump),
        .i_mem_branch_taken (i_mem_branch_taken),
        .i_id_halt          (i_id_halt),
        .i_step_mode        (i_step_mode),
        .i_step             (i_step),
        .o_fwd_a            (o_fwd_a),
        .o_fwd_b            (o_fwd_b),
        .o_pc_write         (o_pc_write),
        .o_if_id_write      (o_if_id_write),
        .o_id_ex_bubble     (o_id_ex_bubble),
        .o_flush_if_id      (o_flush_if_id),
        .o_flush_id_ex      (o_flush_id_ex),
        .o_flush_ex_mem     (o_flush_ex_mem),
        .o_pc_src           (o_pc_src),
        .o_pipe_en          (o_pipe_en),
        .o_halted           (o_halted),
        .o_cycle_count      (o_cycle_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid    = 1'b0;
    bit          m_halted   = 1'b0;
    int          m_drain_left = 0;
    bit          m_stepping = 1'b0;
    bit          m_grant    = 1'b0;
    bit          m_step_prev = 1'b0;
    bit          m_rise_prev = 1'b0;
    logic [1:0]  m_fwd_a    = 2'b00;
    logic [1:0]  m_fwd_b    = 2'b00;
    logic [31:0] m_count    = 32'd0;

    function automatic bit f_pipe_en();
        if (!i_rst || m_halted) return 1'b0;
        if (m_drain_left > 0) return i_step_mode ? m_rise_prev : 1'b1;
        if (m_stepping) return m_grant;
        return 1'b1;
    endfunction

    function automatic logic [1:0] f_fwd(input logic [4:0] src);
        if (src != 5'd0 && i_ex_reg_write && src == i_ex_write_reg) return 2'b01;
        if (src != 5'd0 && i_mem_reg_write && src == i_mem_write_reg) return 2'b10;
        return 2'b00;
    endfunction

    // {pc_write, if_id_write, bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_src}
    function automatic logic [6:0] f_hazard();
        bit lu;
        lu = i_ex_mem_read && i_ex_write_reg != 5'd0 &&
             (i_ex_write_reg == i_id_rs || i_ex_write_reg == i_id_rt);
        if (!f_pipe_en()) return 7'b0000000;
        if (m_drain_left > 0) return 7'b0001000;
        if (i_mem_branch_taken) return 7'b1101111;
        if (lu) return 7'b0010000;
        return {3'b110, i_id_jump, 3'b000};
    endfunction

    always @(posedge i_clk) begin
        bit         en;
        bit         rise;
        logic [6:0] hz;
        en   = f_pipe_en();
        hz   = f_hazard();
        rise = i_step && !m_step_prev;
        if (!i_rst) begin
            m_valid = 1'b1; m_halted = 1'b0; m_drain_left = 0; m_stepping = 1'b0;
            m_grant = 1'b0; m_step_prev = 1'b0; m_rise_prev = 1'b0;
            m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_count = 32'd0;
        end else begin
            if (en) begin
                m_count = m_count + 32'd1;
                m_fwd_a = hz[4] ? 2'b00 : f_fwd(i_id_rs);
                m_fwd_b = hz[4] ? 2'b00 : f_fwd(i_id_rt);
            end
            if (m_halted) begin
                m_halted = 1'b1;
            end else if (m_drain_left > 0) begin
                if (en) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1'b1;
                end
            end else if (m_stepping) begin
                if (m_grant) begin
                    m_grant = 1'b0;
                    if (i_id_halt) begin
                        m_stepping = 1'b0;
                        m_drain_left = DRAIN_CYCLES;
                    end
                end else if (!i_step_mode) begin
                    m_stepping = 1'b0;
                end else if (rise) begin
                    m_grant = 1'b1;
                end
            end else begin
                if (i_id_halt) m_drain_left = DRAIN_CYCLES;
                else if (i_step_mode) m_stepping = 1'b1;
            end
            m_rise_prev = rise;
            m_step_prev = i_step;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge i_clk) begin
        if (m_valid) begin
            check("pipe_en", 32'(o_pipe_en), 32'(f_pipe_en()));
            check("hazard_vec", 32'({o_pc_write, o_if_id_write, o_id_ex_bubble, o_flush_if_id,
                                     o_flush_id_ex, o_flush_ex_mem, o_pc_src}), 32'(f_hazard()));
            check("halted", 32'(o_halted), 32'(m_halted && i_rst));
            check("fwd_a", 32'(o_fwd_a), 32'(m_fwd_a));
            check("fwd_b", 32'(o_fwd_b), 32'(m_fwd_b));
            check("cycle_count", o_cycle_count, m_count);
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [4:0] rs, rt, exw;
        logic       exrw;
        logic [4:0] memw;
        logic       memrw;
        logic [1:0] ea, eb;
    } fwd_vec_t;

    fwd_vec_t    fv[6];
    logic [31:0] base;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ops(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exw,
                           input logic exrw, input logic exmr, input logic [4:0] memw,
                           input logic memrw);
        i_id_rs = rs; i_id_rt = rt; i_ex_write_reg = exw; i_ex_reg_write = exrw;
        i_ex_mem_read = exmr; i_mem_write_reg = memw; i_mem_reg_write = memrw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        fv[0] = '{5'd3, 5'd5, 5'd3, 1'b1, 5'd0, 1'b0, 2'b01, 2'b00};
        fv[1] = '{5'd3, 5'd5, 5'd7, 1'b1, 5'd3, 1'b1, 2'b10, 2'b00};
        fv[2] = '{5'd0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 2'b00, 2'b10};
        fv[3] = '{5'd4, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 2'b01, 2'b01};
        fv[4] = '{5'd6, 5'd9, 5'd6, 1'b0, 5'd9, 1'b0, 2'b00, 2'b00};
        fv[5] = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00};

        set_ops(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        i_id_jump = 1'b0; i_mem_branch_taken = 1'b0; i_id_halt = 1'b0;
        i_step_mode = 1'b0; i_step = 1'b0;

        // Reset state
        tick(); tick();
        @(negedge i_clk);
        check("rst_pipe_en", 32'(o_pipe_en), 32'd0);
        check("rst_fwd_a", 32'(o_fwd_a), 32'd0);
        check("rst_pc_write", 32'(o_pc_write), 32'd0);
        check("rst_halted", 32'(o_halted), 32'd0);
        check("rst_count", o_cycle_count, 32'd0);
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        check("release_pipe_en", 32'(o_pipe_en), 32'd1);
        check("release_count", o_cycle_count, 32'd0);
        tick();

        // Forwarding patterns
        for (int i = 0; i < 6; i++) begin
            set_ops(fv[i].rs, fv[i].rt, fv[i].exw, fv[i].exrw, 1'b0, fv[i].memw, fv[i].memrw);
            tick();
            @(negedge i_clk);
            check($sformatf("fwd_vec%0d_a", i), 32'(o_fwd_a), 32'(fv[i].ea));
            check($sformatf("fwd_vec%0d_b", i), 32'(o_fwd_b), 32'(fv[i].eb));
            tick();
        end

        // Load-use: lw $2 in EX, add $4,$2,$2 in ID
        set_ops(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
        @(negedge i_clk);
        check("lu_pc_write", 32'(o_pc_write), 32'd0);
        check("lu_if_id_write", 32'(o_if_id_write), 32'd0);
        check("lu_bubble", 32'(o_id_ex_bubble), 32'd1);
        tick();
        set_ops(5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
        @(negedge i_clk);
        check("lu_bubble_fwd_a", 32'(o_fwd_a), 32'd0);
        check("lu_resume_pc_write", 32'(o_pc_write), 32'd1);
        check("lu_resume_bubble", 32'(o_id_ex_bubble), 32'd0);
        tick();
        @(negedge i_clk);
        check("lu_add_fwd_a", 32'(o_fwd_a), 32'd2);
        check("lu_add_fwd_b", 32'(o_fwd_b), 32'd2);
        tick();

        // Taken branch with simultaneous load-use and jump
        set_ops(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
        i_mem_branch_taken = 1'b1; i_id_jump = 1'b1;
        @(negedge i_clk);
        check("br_pc_src", 32'(o_pc_src), 32'd1);
        check("br_flushes", 32'({o_flush_if_id, o_flush_id_ex, o_flush_ex_mem}), 32'd7);
        check("br_no_stall", 32'({o_pc_write, o_id_ex_bubble}), 32'b10);
        tick();
        i_mem_branch_taken = 1'b0;
        set_ops(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge i_clk);
        check("jmp_flush_if_id", 32'(o_flush_if_id), 32'd1);
        check("jmp_other_flushes", 32'({o_flush_id_ex, o_flush_ex_mem, o_pc_src}), 32'd0);
        tick();
        i_id_jump = 1'b0;
        @(negedge i_clk);
        check("jmp_single_cycle", 32'(o_flush_if_id), 32'd0);
        tick();

        // Single-step mode
        i_step_mode = 1'b1;
        tick();
        i_mem_branch_taken = 1'b1;
        @(negedge i_clk);
        check("step_wait_pipe_en", 32'(o_pipe_en), 32'd0);
        check("step_wait_gated", 32'({o_pc_write, o_flush_if_id, o_pc_src}), 32'd0);
        tick();
        i_mem_branch_taken = 1'b0;
        base = m_count;
        tick(); tick();
        i_step = 1'b1;
        repeat (5) tick();
        i_step = 1'b0;
        repeat (3) tick();
        @(negedge i_clk);
        check("step_hold_count", o_cycle_count, base + 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            i_step = 1'b1;
            tick();
            i_step = 1'b0;
            tick(); tick();
        end
        @(negedge i_clk);
        check("step_pulses_count", o_cycle_count, base + 32'd4);
        tick();
        i_step_mode = 1'b0;
        tick();
        @(negedge i_clk);
        check("step_exit_pipe_en", 32'(o_pipe_en), 32'd1);
        tick();

        // Halt drain
        base = m_count;
        i_id_halt = 1'b1;
        tick();
        i_id_halt = 1'b0;
        @(negedge i_clk);
        check("drain_pc_write", 32'(o_pc_write), 32'd0);
        check("drain_flush_if_id", 32'(o_flush_if_id), 32'd1);
        tick(); tick();
        @(negedge i_clk);
        check("drain_not_yet_halted", 32'(o_halted), 32'd0);
        tick();
        @(negedge i_clk);
        check("halted", 32'(o_halted), 32'd1);
        check("halted_pipe_en", 32'(o_pipe_en), 32'd0);
        check("halted_count", o_cycle_count, base + 32'd4);
        tick();
        set_ops(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
        i_mem_branch_taken = 1'b1;
        tick();
        @(negedge i_clk);
        check("halted_stays", 32'(o_halted), 32'd1);
        check("halted_count_frozen", o_cycle_count, base + 32'd4);
        tick();
        i_mem_branch_taken = 1'b0;
        set_ops(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Reset out of HALTED
        i_rst = 1'b0;
        tick();
        @(negedge i_clk);
        check("halt_rst_count", o_cycle_count, 32'd0);
        check("halt_rst_halted", 32'(o_halted), 32'd0);
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        check("halt_rst_run", 32'(o_pipe_en), 32'd1);
        tick();

        // Reset while waiting for a step
        i_step_mode = 1'b1;
        tick(); tick();
        i_step_mode = 1'b0;
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        check("step_rst_run", 32'(o_pipe_en), 32'd1);
        check("step_rst_count", o_cycle_count, 32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
